// File: rtl/sha256_sched_pkg.sv
// Shared types and sizing helpers for the round-robin sha256 core scheduler.
// Optional build macro SHA256_SCHED_LOCK_EN is consumed by the interface and top.
package sha256_sched_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha256_rr_sched_if.sv
// Lane and core handshake bundle for sha256_rr_sched; signal suffixes are from the scheduler's view.
// SHA256_SCHED_LOCK_EN adds req_last_i for multi-block ownership.
interface sha256_rr_sched_if #(
  parameter int NUM_REQ_P  = 4,
  parameter int BLOCK_W_P  = sha256_sched_pkg::BLOCK_W,
  parameter int DIGEST_W_P = sha256_sched_pkg::DIGEST_W
);
  logic [NUM_REQ_P-1:0]           req_valid_i;
  logic [NUM_REQ_P*BLOCK_W_P-1:0] req_data_i;
  logic [NUM_REQ_P-1:0]           req_ready_o;
  logic [NUM_REQ_P-1:0]           rsp_valid_o;
  logic [DIGEST_W_P-1:0]          rsp_data_o;
  logic [NUM_REQ_P-1:0]           rsp_ready_i;
  logic                           core_in_valid_o;
  logic [BLOCK_W_P-1:0]           core_in_o;
  logic                           core_in_ready_i;
  logic                           core_out_valid_i;
  logic [DIGEST_W_P-1:0]          core_out_i;
  logic                           core_out_ready_o;
`ifdef SHA256_SCHED_LOCK_EN
  logic [NUM_REQ_P-1:0]           req_last_i;
`endif

  modport slave (
    output req_ready_o, rsp_valid_o, rsp_data_o, core_in_valid_o, core_in_o, core_out_ready_o,
    input  req_valid_i, req_data_i, rsp_ready_i, core_in_ready_i, core_out_valid_i, core_out_i
`ifdef SHA256_SCHED_LOCK_EN
    , req_last_i
`endif
  );

  modport master (
    input  req_ready_o, rsp_valid_o, rsp_data_o, core_in_valid_o, core_in_o, core_out_ready_o,
    output req_valid_i, req_data_i, rsp_ready_i, core_in_ready_i, core_out_valid_i, core_out_i
`ifdef SHA256_SCHED_LOCK_EN
    , req_last_i
`endif
  );
endinterface

// File: rtl/sha256_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or above ptr, wrapping to 0.
module sha256_rr_pick
  import sha256_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  // NOTE: every output gets a default before the search so no path leaves a latch behind.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && valid[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/sha256_rr_sched.sv
// Round-robin scheduler sharing one sha256 core among NUM_REQ_P lanes, one block in flight.
// Define SHA256_SCHED_LOCK_EN to keep a lane's ownership until its block flagged req_last_i.
module sha256_rr_sched
  import sha256_sched_pkg::*;
#(
  parameter int NUM_REQ_P  = 4,
  parameter int BLOCK_W_P  = BLOCK_W,
  parameter int DIGEST_W_P = DIGEST_W
) (
  input logic              clk_i,
  input logic              rst_ni,
  sha256_rr_sched_if.slave bus
);

  localparam int IW = idx_w(NUM_REQ_P);

  state_e                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d, owner_q, owner_d;
  logic [BLOCK_W_P-1:0]   block_q;
  logic [DIGEST_W_P-1:0]  digest_q;
  logic [NUM_REQ_P-1:0]   pick_valid, pick_grant, owner_oh;
  logic [IW-1:0]          pick_idx, pick_nxt;
  logic                   pick_any;

  assign owner_oh = {{(NUM_REQ_P-1){1'b0}}, 1'b1} << owner_q;
  assign pick_nxt = (pick_idx == IW'(NUM_REQ_P-1)) ? '0 : pick_idx + 1'b1;

`ifdef SHA256_SCHED_LOCK_EN
  logic lock_q, lock_d;
  // A locked owner is the only candidate; other lanes are masked out entirely.
  assign pick_valid = lock_q ? (bus.req_valid_i & owner_oh) : bus.req_valid_i;
`else
  assign pick_valid = bus.req_valid_i;
`endif

  sha256_rr_pick #(.N(NUM_REQ_P)) u_pick (
    .valid (pick_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d              = state_q;
    ptr_d                = ptr_q;
    owner_d              = owner_q;
    bus.req_ready_o      = '0;
    bus.rsp_valid_o      = '0;
    bus.core_in_valid_o  = 1'b0;
    bus.core_out_ready_o = 1'b0;
`ifdef SHA256_SCHED_LOCK_EN
    lock_d               = lock_q;
`endif
    unique case (state_q)
      IDLE: if (pick_any) begin
        bus.req_ready_o = pick_grant;
        owner_d         = pick_idx;
        state_d         = ISSUE;
`ifdef SHA256_SCHED_LOCK_EN
        lock_d = ~bus.req_last_i[pick_idx];
        if (bus.req_last_i[pick_idx]) ptr_d = pick_nxt;
`else
        ptr_d  = pick_nxt;
`endif
      end
      ISSUE: begin
        bus.core_in_valid_o = 1'b1;
        if (bus.core_in_ready_i) state_d = WAIT;
      end
      WAIT: begin
        bus.core_out_ready_o = 1'b1;
        if (bus.core_out_valid_i) state_d = RETURN;
      end
      RETURN: begin
        bus.rsp_valid_o = owner_oh;
        if (bus.rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
`ifdef SHA256_SCHED_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
`ifdef SHA256_SCHED_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  // NOTE: the wide data registers are reset too, so core_in_o/rsp_data_o never expose stale blocks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      block_q  <= '0;
      digest_q <= '0;
    end else begin
      if (state_q == IDLE && pick_any)
        block_q <= bus.req_data_i[pick_idx*BLOCK_W_P +: BLOCK_W_P];
      if (state_q == WAIT && bus.core_out_valid_i)
        digest_q <= bus.core_out_i;
    end
  end

  assign bus.core_in_o  = block_q;
  assign bus.rsp_data_o = digest_q;

endmodule

// File: tb/tb_sha256_rr_sched.sv
// Directed bench for sha256_rr_sched: reset, single lane, rotation, core stall, response hold, lock.
// Build with SHA256_SCHED_LOCK_EN defined to exercise multi-block ownership.
module tb_sha256_rr_sched;
  import sha256_sched_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  sha256_rr_sched_if #(.NUM_REQ_P(N), .BLOCK_W_P(BLOCK_W), .DIGEST_W_P(DIGEST_W)) bus ();

  sha256_rr_sched #(.NUM_REQ_P(N), .BLOCK_W_P(BLOCK_W), .DIGEST_W_P(DIGEST_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [BLOCK_W-1:0] blk(input int k);
    return {16{32'hB10C_0000 + 32'(k)}};
  endfunction

  function automatic logic [DIGEST_W-1:0] dig(input int n);
    return {8{32'hD16E_0000 + 32'(n)}};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction for `lane`; the DUT must be IDLE with request valids already driven.
  task automatic do_block(input int lane, input int dn, input int stall, input int hold,
                          input logic [N-1:0] after_valid);
    logic [N-1:0] oh;
    oh = N'(1 << lane);
    #1;
    check("grant", bus.req_ready_o, oh);
    bus.core_in_ready_i = (stall == 0);
    tick();
    bus.req_valid_i = after_valid;
    #1;
    check("issue_valid", bus.core_in_valid_o, 1'b1);
    check("issue_block", bus.core_in_o, blk(lane));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", bus.core_in_valid_o, 1'b1);
      check("stall_block", bus.core_in_o, blk(lane));
      check("stall_nogrant", bus.req_ready_o, '0);
    end
    bus.core_in_ready_i = 1'b1;
    tick();
    check("wait_ready", bus.core_out_ready_o, 1'b1);
    check("wait_noissue", bus.core_in_valid_o, 1'b0);
    tick();
    tick();
    bus.core_out_valid_i = 1'b1;
    bus.core_out_i       = dig(dn);
    tick();
    bus.core_out_valid_i = 1'b0;
    bus.core_out_i       = '0;
    #1;
    check("rsp_valid", bus.rsp_valid_o, oh);
    check("rsp_data", bus.rsp_data_o, dig(dn));
    check("ret_core_ready", bus.core_out_ready_o, 1'b0);
    bus.rsp_ready_i = ~oh;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", bus.rsp_valid_o, oh);
      check("hold_data", bus.rsp_data_o, dig(dn));
      check("hold_nogrant", bus.req_ready_o, '0);
    end
    bus.rsp_ready_i = oh;
    tick();
    bus.rsp_ready_i = '0;
    #1;
    check("rsp_done", bus.rsp_valid_o, '0);
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.req_valid_i      = '0;
    bus.req_data_i       = {blk(3), blk(2), blk(1), blk(0)};
    bus.rsp_ready_i      = '0;
    bus.core_in_ready_i  = 1'b0;
    bus.core_out_valid_i = 1'b0;
    bus.core_out_i       = '0;
`ifdef SHA256_SCHED_LOCK_EN
    bus.req_last_i       = '1;
`endif
    repeat (2) tick();
    check("rst_req_ready", bus.req_ready_o, '0);
    check("rst_rsp_valid", bus.rsp_valid_o, '0);
    check("rst_core_in_valid", bus.core_in_valid_o, 1'b0);
    check("rst_core_out_ready", bus.core_out_ready_o, 1'b0);
    check("rst_core_in", bus.core_in_o, '0);
    rst_n = 1'b1;
    tick();

    // Lane 2 alone; ptr moves to 3.
    bus.req_valid_i = 4'b0100;
    do_block(2, 1, 0, 0, 4'b0000);

    // Reset in WAIT after granting lane 1 (search 3,0,1).
    bus.req_valid_i = 4'b0010;
    #1;
    check("t1_grant", bus.req_ready_o, 4'b0010);
    tick();
    bus.req_valid_i     = '0;
    bus.core_in_ready_i = 1'b1;
    tick();
    check("t1_wait", bus.core_out_ready_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_core_out_ready", bus.core_out_ready_o, 1'b0);
    check("t1_core_in_valid", bus.core_in_valid_o, 1'b0);
    check("t1_rsp_valid", bus.rsp_valid_o, '0);
    check("t1_rsp_data", bus.rsp_data_o, '0);
    check("t1_core_in", bus.core_in_o, '0);
    bus.core_out_valid_i = 1'b1;
    bus.core_out_i       = dig(9);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_post_rsp_valid", bus.rsp_valid_o, '0);
    check("t1_post_core_ready", bus.core_out_ready_o, 1'b0);
    tick();
    check("t1_post_rsp_data", bus.rsp_data_o, '0);
    bus.core_out_valid_i = 1'b0;
    bus.core_out_i       = '0;

    // All lanes valid: ptr back at 0 gives 0,1,2,3,0.
    bus.req_valid_i = 4'b1111;
    do_block(0, 10, 0, 0, 4'b1111);
    do_block(1, 11, 0, 0, 4'b1111);
    do_block(2, 12, 0, 0, 4'b1111);
    do_block(3, 13, 0, 0, 4'b1111);
    do_block(0, 14, 0, 0, 4'b1111);
    bus.req_valid_i = '0;

    // Core stall on lane 3 (ptr 1) while lane 0 also asks.
    bus.req_valid_i = 4'b1000;
    do_block(3, 20, 5, 0, 4'b1001);
    bus.req_valid_i = '0;

    // Owner lane 2 holds off the digest while lane 1 requests and acks.
    bus.req_valid_i = 4'b0100;
    do_block(2, 30, 0, 10, 4'b0010);
    bus.req_valid_i = 4'b0010;
    do_block(1, 31, 0, 0, 4'b0000);

    // ptr is 2; lanes 0 and 1 valid.
    bus.req_valid_i = 4'b0011;
`ifdef SHA256_SCHED_LOCK_EN
    bus.req_last_i = 4'b0000;
    do_block(0, 40, 0, 0, 4'b0011);
    do_block(0, 41, 0, 0, 4'b0011);
    bus.req_last_i = 4'b0001;
    do_block(0, 42, 0, 0, 4'b0011);
    bus.req_last_i = 4'b1111;
    do_block(1, 43, 0, 0, 4'b0000);
`else
    do_block(0, 40, 0, 0, 4'b0011);
    do_block(1, 41, 0, 0, 4'b0000);
`endif
    bus.req_valid_i = '0;
    tick();
    check("end_idle", bus.req_ready_o, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
